hilo_unit: RTL and testbench
============================

Name: hilo_unit

Overview:
- HI/LO special-register stage that sits directly downstream of the combinational divider and multiplier.
- Captures their {HI, LO} results on issue and models the multi-cycle latency of MULT/DIV with a countdown.
- Commits results to the architectural HI/LO registers and services MFHI/MFLO/MTHI/MTLO.
- Raises a pipeline stall when software reads HI/LO before a pending result has committed.

Parameters:
DIV_LAT, 32, cycles from div_start to HI/LO commit (1..2^CNT_W-1)
MUL_LAT, 4, cycles from mul_start to HI/LO commit (1..2^CNT_W-1)
CNT_W, 6, width of latency counter

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
div_start  in  1  DIV issued this cycle; div_hi/div_lo valid this cycle only
div_hi  in  32  remainder from divider
div_lo  in  32  quotient from divider
div_t_zero  in  1  divisor operand == 0, qualified by div_start
mul_start  in  1  MULT issued this cycle; mul_hi/mul_lo valid this cycle only
mul_hi  in  32  upper product word
mul_lo  in  32  lower product word
mthi  in  1  write wdata to HI
mtlo  in  1  write wdata to LO
wdata  in  32  MTHI/MTLO data
mfhi  in  1  read HI request
mflo  in  1  read LO request
rdata  out  32  read data
stall  out  1  hold pipeline: read requested while busy
busy  out  1  operation pending
dz_flag  out  1  sticky divide-by-zero indicator
hi  out  32  architectural HI
lo  out  32  architectural LO

Behaviour:
- Reset (async, reset_n=0): hi, lo, pend_hi, pend_lo, count, dz_flag, pend_dz = 0; busy=0, stall=0, rdata=0. Reset mid-operation discards the pending result.
- States: IDLE (count==0, busy=0) and RUN (count!=0, busy=1); busy = (count!=0).
- Issue:
  - div_start: pend_hi/pend_lo <= div_hi/div_lo; count <= DIV_LAT; pend_dz <= div_t_zero.
  - mul_start: pend <= mul_hi/mul_lo; count <= MUL_LAT; pend_dz <= 0.
  - div_start and mul_start together: div_start wins.
- Issue while RUN: restart with the new operands and latency; the old pending result is discarded and never committed.
- RUN: count decrements each cycle. On the edge where count goes 1->0, hi/lo <= pend_hi/pend_lo, unless pend_dz=1, in which case hi/lo hold their values.
- Timing: DIV_LAT=N means busy is high for exactly N cycles after the issue edge, and the new hi/lo are visible on the cycle busy falls.
- dz_flag:
  - Set on the issue edge of a div_start with div_t_zero=1.
  - Cleared on a div_start with div_t_zero=0, or on mthi/mtlo.
  - Unaffected by mul_start.
- MTHI/MTLO:
  - hi <= wdata (mthi) and/or lo <= wdata (mtlo); both together are allowed.
  - If busy, the pending operation is aborted: count <= 0, no commit.
  - Same-cycle start and mthi/mtlo: the start takes priority (issue proceeds). The mt write is still applied to hi/lo that cycle and is overwritten at commit.
  - mthi/mtlo on the commit edge: the mt write wins for the register it targets; the other register takes the commit value.
- Reads:
  - stall = (mfhi|mflo) & busy, combinational.
  - rdata = mfhi ? hi : (mflo ? lo : 0), combinational; mfhi has priority if both are asserted.
  - While stall=1, rdata is don't-care and the requester holds the request.
  - No forwarding on the commit edge: the read succeeds on the first cycle busy=0.
- Widths: all data is 32-bit with no arithmetic here. count is CNT_W bits; parameters outside 1..2^CNT_W-1 are illegal and must be flagged by simulation assertion.

Test Plan:
- Reset then idle; read mfhi -> rdata=0, stall=0, busy=0.
- div_start with div_hi=2, div_lo=14 (100/7), DIV_LAT=32 -> busy=1 for exactly 32 cycles; then hi=2, lo=14. mflo asserted at cycle 5 -> stall=1 through cycle 32, rdata=14 on cycle 33.
- mul_start with mul_hi=0x00000001, mul_lo=0x00000000, then div_start 2 cycles later (div_hi=1, div_lo=3) -> multiply discarded; after 32 cycles hi=1, lo=3.
- hi=5, lo=6; div_start with div_t_zero=1 -> dz_flag=1 next cycle; after DIV_LAT hi=5, lo=6 unchanged. Next div_start with div_t_zero=0 -> dz_flag=0.
- div_start, then mthi wdata=0xDEADBEEF at cycle 10 -> busy drops next cycle, hi=0xDEADBEEF, lo unchanged, no later commit.
- div_start pulled, then reset_n low at cycle 7 -> all outputs 0 immediately; after release busy=0 and no commit occurs.

Source files
------------

// File: rtl/hilo_unit.sv
// HI/LO special-register stage behind the divider and multiplier.
// Captures results on issue, counts down the op latency, commits to HI/LO and services MF*/MT*.
module hilo_unit #(
  parameter int DIV_LAT = 32,
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        div_start,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  input  logic        div_t_zero,
  input  logic        mul_start,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic        mfhi,
  input  logic        mflo,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        busy,
  output logic        dz_flag,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // state | meaning
  // IDLE  | count == 0, nothing pending, reads are serviced
  // RUN   | count != 0, result pending, reads stall
  typedef enum logic {IDLE, RUN} state_t;

  localparam int MAX_LAT = (1 << CNT_W) - 1;

  state_t           state;
  logic [CNT_W-1:0] count, count_nxt;
  logic [31:0]      pend_hi, pend_lo, pend_hi_nxt, pend_lo_nxt;
  logic [31:0]      hi_nxt, lo_nxt;
  logic             pend_dz, pend_dz_nxt, dz_nxt;
  logic             mt_any, commit;

  assign state  = (count != '0) ? RUN : IDLE;
  assign busy   = (state == RUN);
  assign mt_any = mthi | mtlo;
  // A new issue on the final countdown cycle discards the old result.
  assign commit = busy && (count == CNT_W'(1)) && !div_start && !mul_start && !pend_dz;

  assign stall = (mfhi | mflo) & busy;
  assign rdata = mfhi ? hi : (mflo ? lo : 32'h0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      pend_hi <= 32'h0;
      pend_lo <= 32'h0;
      pend_dz <= 1'b0;
      dz_flag <= 1'b0;
      hi      <= 32'h0;
      lo      <= 32'h0;
    end else begin
      count   <= count_nxt;
      pend_hi <= pend_hi_nxt;
      pend_lo <= pend_lo_nxt;
      pend_dz <= pend_dz_nxt;
      dz_flag <= dz_nxt;
      hi      <= hi_nxt;
      lo      <= lo_nxt;
    end
  end

  always_comb begin
    count_nxt   = count;
    pend_hi_nxt = pend_hi;
    pend_lo_nxt = pend_lo;
    pend_dz_nxt = pend_dz;
    dz_nxt      = dz_flag;
    hi_nxt      = hi;
    lo_nxt      = lo;

    case (state)
      IDLE: count_nxt = '0;
      RUN:  count_nxt = mt_any ? '0 : count - 1'b1;
      default: count_nxt = '0;
    endcase

    if (commit) begin
      hi_nxt = pend_hi;
      lo_nxt = pend_lo;
    end
    // MT writes override the commit only for the register they target.
    if (mthi) hi_nxt = wdata;
    if (mtlo) lo_nxt = wdata;
    if (mt_any) dz_nxt = 1'b0;

    if (div_start) begin
      pend_hi_nxt = div_hi;
      pend_lo_nxt = div_lo;
      pend_dz_nxt = div_t_zero;
      dz_nxt      = div_t_zero;
      count_nxt   = CNT_W'(DIV_LAT);
    end else if (mul_start) begin
      pend_hi_nxt = mul_hi;
      pend_lo_nxt = mul_lo;
      pend_dz_nxt = 1'b0;
      count_nxt   = CNT_W'(MUL_LAT);
    end
  end

  a_div_lat: assert property (@(posedge clk) (DIV_LAT >= 1) && (DIV_LAT <= MAX_LAT))
    else $error("hilo_unit: DIV_LAT outside 1..2^CNT_W-1");
  a_mul_lat: assert property (@(posedge clk) (MUL_LAT >= 1) && (MUL_LAT <= MAX_LAT))
    else $error("hilo_unit: MUL_LAT outside 1..2^CNT_W-1");

endmodule

// File: tb/tb_hilo_unit.sv
// Bench for hilo_unit: vector table for MF/MT traffic plus a commit scoreboard for MULT/DIV.
module tb_hilo_unit;

  localparam int DIV_LAT = 32;
  localparam int MUL_LAT = 4;
  localparam int BUDGET  = 200;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        div_start = 1'b0, div_t_zero = 1'b0, mul_start = 1'b0;
  logic [31:0] div_hi = '0, div_lo = '0, mul_hi = '0, mul_lo = '0, wdata = '0;
  logic        mthi = 1'b0, mtlo = 1'b0, mfhi = 1'b0, mflo = 1'b0;
  logic [31:0] rdata, hi, lo;
  logic        stall, busy, dz_flag;

  hilo_unit #(.DIV_LAT(DIV_LAT), .MUL_LAT(MUL_LAT), .CNT_W(6)) dut (
    .clk(clk), .reset_n(reset_n),
    .div_start(div_start), .div_hi(div_hi), .div_lo(div_lo), .div_t_zero(div_t_zero),
    .mul_start(mul_start), .mul_hi(mul_hi), .mul_lo(mul_lo),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .mfhi(mfhi), .mflo(mflo),
    .rdata(rdata), .stall(stall), .busy(busy), .dz_flag(dz_flag), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mthi, mtlo;
    logic [31:0] wdata;
    logic        mfhi, mflo;
    logic [31:0] exp_rdata, exp_hi, exp_lo;
  } vec_t;

  typedef struct {
    int          lat;
    logic [31:0] hi, lo;
    logic        dz;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit dv, input bit ml, input logic [31:0] h, input logic [31:0] l,
                       input bit tz);
    if (dv) begin div_start = 1'b1; div_hi = h; div_lo = l; div_t_zero = tz; end
    if (ml) begin mul_start = 1'b1; mul_hi = h; mul_lo = l; end
    tick();
    div_start = 1'b0; mul_start = 1'b0; div_t_zero = 1'b0;
  endtask

  // Waits for busy to fall; cyc counts edges since the issue edge. rd_at != 0 raises mflo
  // from that cycle on and expects stall until the commit, then the committed LO.
  task automatic wait_commit(input int elapsed, input int rd_at);
    exp_t e;
    int   cyc = elapsed;
    int   stall_bad = 0;
    while (busy && cyc < BUDGET) begin
      if (rd_at != 0 && cyc >= rd_at) begin
        mflo = 1'b1;
        #1;
        if (stall !== 1'b1) stall_bad++;
      end
      tick();
      cyc++;
    end
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check("commit_latency", cyc, e.lat);
    check("commit_hi", hi, e.hi);
    check("commit_lo", lo, e.lo);
    check("commit_dz", {31'd0, dz_flag}, {31'd0, e.dz});
    if (rd_at != 0) begin
      #1;
      check("stall_while_busy", stall_bad, 0);
      check("read_after_commit", rdata, e.lo);
      check("stall_after_commit", {31'd0, stall}, 32'd0);
      mflo = 1'b0;
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,        32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'hA5A50001, 1'b0, 1'b0, 32'h0,        32'hA5A50001, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 32'h00001234, 1'b1, 1'b0, 32'hA5A50001, 32'hA5A50001, 32'h00001234};
    vecs[3] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hA5A50001, 32'hA5A50001, 32'h00001234};
    vecs[4] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h00001234, 32'hA5A50001, 32'h00001234};
    vecs[5] = '{1'b1, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1, 32'h00001234, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[6] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D};

    repeat (2) tick();
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Idle after reset
    mfhi = 1'b1;
    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_dz", {31'd0, dz_flag}, 32'd0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    mfhi = 1'b0;
    tick();

    foreach (vecs[i]) begin
      mthi = vecs[i].mthi; mtlo = vecs[i].mtlo; wdata = vecs[i].wdata;
      mfhi = vecs[i].mfhi; mflo = vecs[i].mflo;
      #1;
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_stall", i), {31'd0, stall}, 32'd0);
      tick();
      mthi = 1'b0; mtlo = 1'b0; mfhi = 1'b0; mflo = 1'b0;
      check($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
    end

    // 100/7 divide with an early MFLO that must stall
    issue(1, 0, 32'd2, 32'd14, 0);
    sb.push_back('{DIV_LAT, 32'd2, 32'd14, 1'b0});
    wait_commit(0, 5);

    issue(0, 1, 32'h12345678, 32'h9ABCDEF0, 0);
    sb.push_back('{MUL_LAT, 32'h12345678, 32'h9ABCDEF0, 1'b0});
    wait_commit(0, 0);

    // Multiply overtaken by a divide two cycles later
    issue(0, 1, 32'h1, 32'h0, 0);
    sb.push_back('{MUL_LAT, 32'h1, 32'h0, 1'b0});
    tick();
    issue(1, 0, 32'd1, 32'd3, 0);
    sb.delete();
    sb.push_back('{DIV_LAT, 32'd1, 32'd3, 1'b0});
    repeat (4) tick();
    check("discarded_mul_hi", hi, 32'h12345678);
    check("discarded_mul_lo", lo, 32'h9ABCDEF0);
    wait_commit(4, 0);

    // Divide by zero keeps HI/LO, sets the sticky flag; MULT leaves it alone
    mthi = 1'b1; wdata = 32'd5; tick(); mthi = 1'b0;
    mtlo = 1'b1; wdata = 32'd6; tick(); mtlo = 1'b0;
    issue(1, 0, 32'd99, 32'd98, 1);
    check("dz_set", {31'd0, dz_flag}, 32'd1);
    sb.push_back('{DIV_LAT, 32'd5, 32'd6, 1'b1});
    wait_commit(0, 0);
    issue(0, 1, 32'd7, 32'd8, 0);
    sb.push_back('{MUL_LAT, 32'd7, 32'd8, 1'b1});
    wait_commit(0, 0);
    issue(1, 0, 32'd1, 32'd2, 0);
    check("dz_clear", {31'd0, dz_flag}, 32'd0);
    sb.push_back('{DIV_LAT, 32'd1, 32'd2, 1'b0});
    wait_commit(0, 0);

    // MTHI mid-divide aborts the operation
    issue(1, 0, 32'h11, 32'h22, 0);
    repeat (9) tick();
    mthi = 1'b1; wdata = 32'hDEADBEEF;
    tick();
    mthi = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'hDEADBEEF);
    check("abort_lo", lo, 32'd2);
    repeat (40) tick();
    check("abort_no_commit_hi", hi, 32'hDEADBEEF);
    check("abort_no_commit_lo", lo, 32'd2);

    // MTLO on the commit edge: LO from the write, HI from the commit
    issue(0, 1, 32'hA, 32'hB, 0);
    sb.push_back('{MUL_LAT, 32'hA, 32'h77, 1'b0});
    repeat (3) tick();
    mtlo = 1'b1; wdata = 32'h77;
    tick();
    mtlo = 1'b0;
    wait_commit(MUL_LAT, 0);

    // Issue with MTHI in the same cycle: write lands, then commit overwrites
    mthi = 1'b1; wdata = 32'h55;
    issue(0, 1, 32'hC, 32'hD, 0);
    mthi = 1'b0;
    check("start_mt_hi", hi, 32'h55);
    check("start_mt_busy", {31'd0, busy}, 32'd1);
    sb.push_back('{MUL_LAT, 32'hC, 32'hD, 1'b0});
    wait_commit(0, 0);

    // DIV and MULT together: divide wins
    mul_hi = 32'hEEEE; mul_lo = 32'hFFFF;
    mul_start = 1'b1;
    issue(1, 0, 32'h31, 32'h32, 0);
    sb.push_back('{DIV_LAT, 32'h31, 32'h32, 1'b0});
    wait_commit(0, 0);

    // Reset in the middle of a divide
    issue(1, 0, 32'h41, 32'h42, 1);
    repeat (6) tick();
    reset_n = 1'b0;
    mfhi = 1'b1;
    #1;
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_dz", {31'd0, dz_flag}, 32'd0);
    check("midrst_rdata", rdata, 32'h0);
    check("midrst_stall", {31'd0, stall}, 32'd0);
    mfhi = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) tick();
    check("postrst_busy", {31'd0, busy}, 32'd0);
    check("postrst_hi", hi, 32'h0);
    check("postrst_lo", lo, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
